alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised multi-cycle ALU with valid/ready handshakes on input and output.
//  Performs add, sub, logic, shift and (optional) iterative multiply, producing NZCV flags.
//  Sits between operand fetch and writeback in the datapath.
//  Registered output; single-cycle ops take 1 cycle, multiply takes WIDTH+1 cycles.
// PARAMETERS
//  WIDTH    32                 operand/result width, >=8, power of two
//  SHW      $clog2(WIDTH)      shift-amount width (derived localparam, not overridable)
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      operands/op valid
//  in_ready   out  1      block accepts operands this cycle
//  op         in   4      operation code (alu_pkg::alu_op_e)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B; shift amount = b[SHW-1:0]
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer accepts result this cycle
//  result     out  WIDTH  registered result
//  flags      out  4      {N,Z,C,V}, registered with result
//  err        out  1      illegal op; registered with result
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0, result=0, flags=0, err=0; in_ready=1 the cycle after reset drops.
//  States: IDLE, MUL, DONE.
//   IDLE: in_ready=1. Accept (in_valid&in_ready): non-MUL op -> result/flags/err registered, go DONE
//         (out_valid=1 next cycle, latency 1). MUL -> load multiplier, go MUL.
//   MUL : in_ready=0; one shift-add step/cycle, WIDTH steps; after last step write result, go DONE.
//   DONE: out_valid=1; result/flags/err stable while out_ready=0.
//         in_ready = out_ready. out_ready&in_valid: new op accepted same cycle (back-to-back, no bubble).
//         out_ready&!in_valid -> IDLE, out_valid=0.
//  Ops: 0 ADD a+b; 1 SUB a+~b+1; 2 AND; 3 OR; 4 XOR; 5 LSL; 6 LSR; 7 ASR; 8 MUL (low WIDTH bits).
//  Ops 9..15 (and 8 without macro): result=0, flags=0100, err=1, latency 1.
//  Flags: N=result[WIDTH-1]; Z=(result==0) for every op.
//   ADD/SUB: sum is WIDTH+1 bits; C=sum[WIDTH] (SUB: C=1 means no borrow);
//            V=~(a[MSB]^b[MSB]^sub) & (a[MSB]^sum[MSB-1... i.e. result MSB]).
//   LSL/LSR/ASR: C=last bit shifted out; shamt=0 -> result=a, C=0. V=0.
//   AND/OR/XOR/MUL: C=0, V=0.
//  Reset mid-MUL or in DONE: abort, discard result, out_valid=0 next cycle; no partial output.
//  in_valid while in_ready=0: ignored, inputs need not be held by block (producer holds per handshake).
// CONFIGURATION
//  ALU_SEQ_MUL_EN defined: op 8 = iterative multiply via alu_mul_iter, latency WIDTH+1.
//  Not defined: MUL state and alu_mul_iter absent; op 8 treated as illegal (err=1, result 0, latency 1).
// STRUCTURE
//  alu_pkg: alu_op_e enum (4-bit, codes above), flag index localparams FLAG_N/Z/C/V=3/2/1/0,
//           alu_state_e {IDLE,MUL,DONE}.
//  Sub-module alu_mul_iter (only with ALU_SEQ_MUL_EN): start, a, b -> busy, done, product[WIDTH-1:0];
//  shift-add, one bit of b per cycle. Combinational op datapath stays in alu_seq.
// TESTING (WIDTH=32 unless stated; out_ready=1 unless stated)
//  ADD 0x7FFFFFFF+0x1 -> result 0x80000000, flags 1001, out_valid 1 cycle after accept.
//  SUB 5-5 -> 0x0, flags 0110; SUB 3-5 -> 0xFFFFFFFE, flags 1000.
//  ASR 0x80000010 by 4 -> 0xF8000001, C=0; LSR 0x3 by 1 -> 0x1, C=1; LSL 0x1 by 0 -> 0x1, C=0.
//  MUL 0x00010003*0x7 -> 0x00070015, flags 0000, out_valid 33 cycles after accept;
//   macro off -> result 0, err=1, flags 0100 after 1 cycle.
//  Backpressure: out_ready=0 for 5 cycles after ADD result -> result/flags stable, in_ready=0;
//   raise out_ready with in_valid=1 (XOR 0xF0F0^0xFFFF) -> accepted same cycle, 0x0F0F next.
//  Assert reset at step 10 of MUL -> out_valid=0 next cycle, in_ready=1 after release, no stale result.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU.
//   alu_op_e    : 4-bit operation codes presented on alu_seq.op
//   alu_state_e : control FSM states of alu_seq
//   FLAG_*      : bit positions of N/Z/C/V inside the 4-bit flags word
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_LSL = 4'd5,
    OP_LSR = 4'd6,
    OP_ASR = 4'd7,
    OP_MUL = 4'd8
  } alu_op_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one bit of b consumed per cycle.
// Only present when ALU_SEQ_MUL_EN is defined.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : load a/b and begin (ignored result of any run in flight)
//   a, b       : multiplicand / multiplier
//   busy       : steps still pending
//   done       : one-cycle pulse, product valid this cycle
//   product    : low WIDTH bits of a*b
`ifdef ALU_SEQ_MUL_EN
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        acc_q    <= '0;
        mcand_q  <= a;
        mplier_q <= b;
        cnt_q    <= CW'(WIDTH);
        busy_q   <= 1'b1;
      end else if (busy_q) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - CW'(1);
        // Final step: product settles in acc_q, announced the following cycle.
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = acc_q;

endmodule
`endif

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes on both sides and registered
// result, NZCV flags and illegal-op error.
// Optional feature macro: ALU_SEQ_MUL_EN (op 8 = iterative multiply, WIDTH+1
// cycle latency); without it op 8 is illegal like codes 9..15.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (op, a, b)
//   op, a, b            : operation code, operands; shift amount = b[SHW-1:0]
//   out_valid/out_ready : result handshake
//   result, flags, err  : registered result, {N,Z,C,V}, illegal-op flag
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int unsigned SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;

  // ---------------- single-cycle datapath ----------------
  alu_op_e          op_e;
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   shl, shr, sar;
  logic [WIDTH-1:0] dp_result;
  logic             dp_c, dp_v, dp_err;
  logic [3:0]       dp_flags;

  assign op_e   = alu_op_e'(op);
  assign is_sub = (op_e == OP_SUB);
  assign b_eff  = is_sub ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  assign shamt  = b[SHW-1:0];
  // One guard bit beyond the operand catches the last bit shifted out;
  // a zero shift leaves the guard at 0 so C=0 falls out naturally.
  assign shl    = {1'b0, a} << shamt;
  assign shr    = {a, 1'b0} >> shamt;
  assign sar    = $unsigned($signed({a, 1'b0}) >>> shamt);

  always_comb begin
    dp_result = '0;
    dp_c      = 1'b0;
    dp_v      = 1'b0;
    dp_err    = 1'b0;
    case (op_e)
      OP_ADD, OP_SUB: begin
        dp_result = sum[WIDTH-1:0];
        dp_c      = sum[WIDTH];
        dp_v      = ~(a[WIDTH-1] ^ b_eff[WIDTH-1]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
      end
      OP_AND: dp_result = a & b;
      OP_OR:  dp_result = a | b;
      OP_XOR: dp_result = a ^ b;
      OP_LSL: begin
        dp_result = shl[WIDTH-1:0];
        dp_c      = shl[WIDTH];
      end
      OP_LSR: begin
        dp_result = shr[WIDTH:1];
        dp_c      = shr[0];
      end
      OP_ASR: begin
        dp_result = sar[WIDTH:1];
        dp_c      = sar[0];
      end
      default: dp_err = 1'b1;  // includes OP_MUL when the multiplier is absent
    endcase
  end

  always_comb begin
    dp_flags         = '0;
    dp_flags[FLAG_N] = dp_result[WIDTH-1];
    dp_flags[FLAG_Z] = (dp_result == '0);
    dp_flags[FLAG_C] = dp_c;
    dp_flags[FLAG_V] = dp_v;
  end

  // ---------------- multiplier ----------------
`ifdef ALU_SEQ_MUL_EN
  logic             mul_start, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [3:0]       mul_flags;
  logic             is_mul;

  assign is_mul = (op_e == OP_MUL);

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .a      (a),
    .b      (b),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_N] = mul_product[WIDTH-1];
    mul_flags[FLAG_Z] = (mul_product == '0);
  end
`else
  logic is_mul;
  assign is_mul = 1'b0;
`endif

  // ---------------- control FSM ----------------
  logic accept;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    err_d    = err_q;
    in_ready = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    mul_start = 1'b0;
`endif

    unique case (state_q)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;  // back-to-back accept as the result drains
      default: in_ready = 1'b0;
    endcase
    accept = in_valid & in_ready;

    if (accept) begin
      if (is_mul) begin
`ifdef ALU_SEQ_MUL_EN
        mul_start = 1'b1;
`endif
        state_d = MUL;
      end else begin
        result_d = dp_result;
        flags_d  = dp_flags;
        err_d    = dp_err;
        state_d  = DONE;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end

`ifdef ALU_SEQ_MUL_EN
    if (state_q == MUL && mul_done && !mul_busy) begin
      result_d = mul_product;
      flags_d  = mul_flags;
      err_d    = 1'b0;
      state_d  = DONE;
    end
`else
    if (state_q == MUL) state_d = IDLE;  // unreachable without the multiplier
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): directed cases followed by
// random operations checked against an arithmetic reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_seq #(
    .WIDTH(32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flags    (flags),
    .err      (err)
  );

`ifdef ALU_SEQ_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {err, N, Z, C, V, result[31:0]}.
  function automatic logic [36:0] model(input logic [3:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    logic [31:0] r;
    logic        c, v, e;
    int          sx, sy, s;
    longint      wide;
    r  = 32'd0;
    c  = 1'b0;
    v  = 1'b0;
    e  = 1'b0;
    sx = $signed(x);
    sy = $signed(y);
    s  = int'(y[4:0]);
    case (o)
      4'd0: begin
        wide = longint'(x) + longint'(y);
        r    = x + y;
        c    = (wide > 64'sd4294967295);
        wide = longint'(sx) + longint'(sy);
        v    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'd1: begin
        r    = x - y;
        c    = (x >= y);
        wide = longint'(sx) - longint'(sy);
        v    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: begin
        r = x << s;
        c = (s == 0) ? 1'b0 : x[32-s];
      end
      4'd6: begin
        r = x >> s;
        c = (s == 0) ? 1'b0 : x[s-1];
      end
      4'd7: begin
        r = $unsigned(sx >>> s);
        c = (s == 0) ? 1'b0 : x[s-1];
      end
      4'd8: begin
        if (MulEn) r = x * y;
        else e = 1'b1;
      end
      default: e = 1'b1;
    endcase
    return {e, r[31], (r == 32'd0), c, v, r};
  endfunction

  function automatic int exp_latency(input logic [3:0] o);
    return (o == 4'd8 && MulEn) ? 33 : 1;
  endfunction

  // Called at a negedge; returns at the negedge where out_valid was observed.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y);
    logic [36:0] m;
    int          n;
    m        = model(o, x, y);
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_latency(o)));
    check({tag, " result"}, result, m[31:0]);
    check({tag, " flags"}, 32'(flags), 32'(m[35:32]));
    check({tag, " err"}, 32'(err), 32'(m[36]));
  endtask

  initial begin
    logic [31:0] held_r;
    logic [3:0]  held_f;
    int          stale;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 4'd0;
    a         = 32'd0;
    b         = 32'd0;
    repeat (2) @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset flags", 32'(flags), 32'd0);
    check("reset err", 32'(err), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", 32'(in_ready), 32'd1);

    // Directed cases with hand-derived expectations.
    run_op("add ovf", 4'd0, 32'h7FFF_FFFF, 32'h1);
    check("add ovf const", {result[31:0]}, 32'h8000_0000);
    check("add ovf nzcv", 32'(flags), 32'b1001);
    run_op("sub eq", 4'd1, 32'd5, 32'd5);
    check("sub eq nzcv", 32'(flags), 32'b0110);
    run_op("sub borrow", 4'd1, 32'd3, 32'd5);
    check("sub borrow res", result, 32'hFFFF_FFFE);
    check("sub borrow nzcv", 32'(flags), 32'b1000);
    run_op("asr", 4'd7, 32'h8000_0010, 32'd4);
    check("asr res", result, 32'hF800_0001);
    run_op("lsr", 4'd6, 32'h3, 32'd1);
    check("lsr c", 32'(flags[1]), 32'd1);
    run_op("lsl0", 4'd5, 32'h1, 32'd0);
    check("lsl0 res", result, 32'h1);
    run_op("mul", 4'd8, 32'h0001_0003, 32'h7);
    if (MulEn) check("mul res", result, 32'h0007_0015);
    else check("mul illegal err", 32'(err), 32'd1);
    run_op("illegal", 4'd12, 32'hDEAD_BEEF, 32'h1234);
    check("illegal nzcv", 32'(flags), 32'b0100);

    // Backpressure, then back-to-back accept as the result drains.
    @(negedge clk);
    out_ready = 1'b0;
    run_op("bp add", 4'd0, 32'd100, 32'd23);
    held_r = 32'd123;
    held_f = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp result", result, held_r);
      check("bp flags", 32'(flags), 32'(held_f));
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp out_valid", 32'(out_valid), 32'd1);
    end
    op        = 4'd4;
    a         = 32'h0000_F0F0;
    b         = 32'h0000_FFFF;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("b2b in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b out_valid", 32'(out_valid), 32'd1);
    check("b2b result", result, 32'h0000_0F0F);
    @(negedge clk);

    // Reset in the middle of a multiply.
    op       = 4'd8;
    a        = 32'h1234_5678;
    b        = 32'h9ABC_DEF1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort result", result, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort in_ready", 32'(in_ready), 32'd1);
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("abort no stale", 32'(stale), 32'd0);

    // Random operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [3:0] ro;
      ro = 4'($urandom_range(0, 15));
      if (i % 3 == 0) ro = 4'($urandom_range(0, 8));
      run_op($sformatf("rand%0d op%0d", i, ro), ro, $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
